// File: rtl/pd_driver_if.sv
// Codeword stream and device register port seen by pd_driver.
// master = sequencer side, slave = upstream client + device side.
interface pd_driver_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  addr;
    logic        hwen;
    logic        hren;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        interrupt;

    modport master (
        input  in_valid, in_data, rdata, interrupt,
        output in_ready, addr, hwen, hren, wdata
    );

    modport slave (
        output in_valid, in_data, rdata, interrupt,
        input  in_ready, addr, hwen, hren, wdata
    );
endinterface

// File: rtl/pd_driver.sv
// Sequencer that loads WRDS codewords into the matcher device,
// runs it with interrupt enabled and reports match/timeout/cycles.
module pd_driver #(
    parameter int WRDS    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    pd_driver_if.master bus,
    input  logic [7:0]  ctr_value,
    output logic        busy,
    output logic        done,
    output logic        matched,
    output logic        timeout,
    output logic [15:0] cycles
);
    localparam int KW = (WRDS > 1) ? $clog2(WRDS) : 1;
    localparam int SW = $clog2(2 * WRDS);
    localparam logic [15:0]   TO     = 16'(TIMEOUT);
    localparam logic [KW-1:0] K_LAST = KW'(WRDS - 1);
    localparam logic [SW-1:0] S_LAST = SW'(2 * WRDS - 1);

    localparam logic [4:0] A_DATA = 5'd0;
    localparam logic [4:0] A_PTR  = 5'd8;
    localparam logic [4:0] A_CR   = 5'd16;
    localparam logic [4:0] A_ST   = 5'd24;

    typedef enum logic [2:0] {
        S_FILL, S_LOAD, S_START, S_WAIT,
        S_READ, S_CLEAR, S_DONE
    } state_t;

    state_t        state, state_n;
    logic [KW-1:0] k;
    logic [SW-1:0] step, step_n;
    logic [31:0]   words [WRDS];
    logic [7:0]    ctr;
    logic [15:0]   wcnt, wcnt_inc;
    logic          abort, hit;
    logic          accept, last;

    logic          in_ready_n, busy_n, hwen_n, hren_n, done_n;
    logic [4:0]    addr_n;
    logic [31:0]   wdata_n;
    logic          unused_rdata;

    assign accept   = bus.in_valid && bus.in_ready;
    assign last     = (k == K_LAST);
    assign wcnt_inc = (wcnt >= TO) ? TO : wcnt + 16'd1;
    assign step_n   = (state == S_LOAD) ? step + SW'(1) : '0;
    assign unused_rdata = ^{bus.rdata[31:11], bus.rdata[9:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FILL;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_FILL:  if (accept && last) state_n = S_LOAD;
            S_LOAD:  if (step == S_LAST) state_n = S_START;
            S_START: state_n = S_WAIT;
            S_WAIT: begin
                if (bus.interrupt)        state_n = S_READ;
                else if (wcnt_inc == TO)  state_n = S_CLEAR;
            end
            S_READ:  state_n = S_CLEAR;
            S_CLEAR: state_n = S_DONE;
            S_DONE:  state_n = S_FILL;
            default: state_n = S_FILL;
        endcase
    end

    // Outputs are registered, so decode the state being entered.
    always_comb begin
        in_ready_n = 1'b0;
        busy_n     = 1'b1;
        hwen_n     = 1'b0;
        hren_n     = 1'b0;
        done_n     = 1'b0;
        addr_n     = '0;
        wdata_n    = '0;
        unique case (state_n)
            S_FILL: begin
                in_ready_n = 1'b1;
                busy_n     = 1'b0;
            end
            S_LOAD: begin
                hwen_n = 1'b1;
                if (step_n[0]) begin
                    addr_n  = A_DATA;
                    wdata_n = words[KW'(step_n >> 1)];
                end else begin
                    addr_n  = A_PTR;
                    wdata_n = 32'(step_n >> 1);
                end
            end
            S_START: begin
                hwen_n  = 1'b1;
                addr_n  = A_CR;
                wdata_n = {22'd0, 2'b11, ctr};
            end
            S_READ: begin
                hren_n = 1'b1;
                addr_n = A_ST;
            end
            S_CLEAR: begin
                hwen_n = 1'b1;
                addr_n = A_CR;
            end
            S_DONE:  done_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k     <= '0;
            step  <= '0;
            ctr   <= '0;
            wcnt  <= '0;
            abort <= 1'b0;
            hit   <= 1'b0;
            for (int i = 0; i < WRDS; i++) words[i] <= '0;
        end else begin
            step <= step_n;
            if (state == S_FILL && accept) begin
                words[k] <= bus.in_data;
                k        <= last ? '0 : k + KW'(1);
                if (last) ctr <= ctr_value;
            end
            if (state == S_START) begin
                wcnt  <= '0;
                abort <= 1'b0;
                hit   <= 1'b0;
            end
            if (state == S_WAIT) begin
                wcnt <= wcnt_inc;
                if (state_n == S_CLEAR) abort <= 1'b1;
            end
            if (state == S_READ) hit <= bus.rdata[10];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.in_ready <= 1'b1;
            busy         <= 1'b0;
            bus.hwen     <= 1'b0;
            bus.hren     <= 1'b0;
            done         <= 1'b0;
            bus.addr     <= '0;
            bus.wdata    <= '0;
            matched      <= 1'b0;
            timeout      <= 1'b0;
            cycles       <= '0;
        end else begin
            bus.in_ready <= in_ready_n;
            busy         <= busy_n;
            bus.hwen     <= hwen_n;
            bus.hren     <= hren_n;
            done         <= done_n;
            bus.addr     <= addr_n;
            bus.wdata    <= wdata_n;
            if (state_n == S_DONE) begin
                timeout <= abort;
                matched <= hit & ~abort;
                cycles  <= wcnt;
            end
        end
    end
endmodule

// File: tb/tb_pd_driver.sv
// Directed bench for pd_driver with a small behavioural
// model of the matcher device on the register port.
module tb_pd_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  ctr_value = '0;
    logic        busy, done, matched, timeout;
    logic [15:0] cycles;

    pd_driver_if bus ();

    pd_driver #(.WRDS(4), .TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ctr_value (ctr_value),
        .busy      (busy),
        .done      (done),
        .matched   (matched),
        .timeout   (timeout),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // device model
    logic running = 1'b0;
    logic int_en  = 1'b0;
    logic st_bit  = 1'b0;
    logic stale   = 1'b0;
    int   dcnt    = 0;
    int   dev_n   = 0;

    assign bus.rdata = (bus.addr == 5'd24) ?
                       {21'd0, st_bit, 10'd0} : 32'd0;
    assign bus.interrupt = (int_en && !running) ||
                           (stale && !int_en);

    always @(posedge clk) begin
        if (bus.hwen && bus.addr == 5'd16) begin
            running <= bus.wdata[8];
            int_en  <= bus.wdata[9];
            dcnt    <= 1;
        end else if (running) begin
            dcnt <= dcnt + 1;
            if (dev_n > 1 && dcnt == dev_n - 1) running <= 1'b0;
        end
    end

    // bus monitor
    logic [31:0] acc_q [$];
    logic [4:0]  wa_q [$];
    logic [31:0] wd_q [$];
    int          wc_q [$];
    int          last_acc = 0;
    int          rd_n = 0;
    int          rd_cyc = 0;
    int          bad_strb = 0;

    always @(negedge clk) begin
        if (bus.in_valid && bus.in_ready) begin
            acc_q.push_back(bus.in_data);
            last_acc = cyc;
        end
        if (bus.hwen) begin
            wa_q.push_back(bus.addr);
            wd_q.push_back(bus.wdata);
            wc_q.push_back(cyc);
        end
        if (bus.hren) begin
            rd_n++;
            rd_cyc = cyc;
        end
        if (bus.hwen && bus.hren) bad_strb++;
        if (!busy && (bus.hwen || bus.hren)) bad_strb++;
    end

    task automatic feed(input logic [31:0] w [4],
                        input bit bp, input bit hold);
        int i = 0;
        int g = 0;
        bit ph = 1'b0;
        while (i < 4 && g < 200) begin
            @(posedge clk); #1;
            if (bp && ph) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = w[i];
            end
            ph = !ph;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) i++;
            g++;
        end
        if (i < 4) check("feed_bound", i, 4);
        if (hold) begin
            repeat (4) begin
                @(posedge clk); #1;
                bus.in_valid = 1'b1;
                bus.in_data  = 32'hdead_beef;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_job(input logic [31:0] w [4],
                           input logic [7:0] ctr,
                           input int n, input logic m,
                           input bit bp, input bit hold);
        logic [4:0]  ea [10];
        logic [31:0] ed [10];
        int g = 0;
        int wb = wa_q.size();
        int ab = acc_q.size();
        int rb = rd_n;
        int t_done = (n == 0) ? 27 : 12 + n;
        int t_clr  = (n == 0) ? 26 : 11 + n;
        for (int i = 0; i < 4; i++) begin
            ea[2*i]   = 5'd8;
            ed[2*i]   = i;
            ea[2*i+1] = 5'd0;
            ed[2*i+1] = w[i];
        end
        ea[8] = 5'd16;
        ed[8] = {22'd0, 2'b11, ctr};
        ea[9] = 5'd16;
        ed[9] = 32'd0;
        dev_n     = n;
        st_bit    = m;
        ctr_value = ctr;
        feed(w, bp, hold);
        while (!done && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("done_bound", (g < 100), 1);
        check("done_cyc", cyc - last_acc, t_done);
        check("timeout", timeout, (n == 0));
        check("matched", matched, (n != 0) && m);
        check("cycles", cycles, (n == 0) ? 16 : n);
        check("reads", rd_n - rb, (n != 0));
        if (n != 0) check("read_cyc", rd_cyc - last_acc, 10 + n);
        check("accepts", acc_q.size() - ab, 4);
        for (int i = 0; i < 4; i++)
            if (ab + i < acc_q.size())
                check("word", acc_q[ab+i], w[i]);
        check("n_writes", wa_q.size() - wb, 10);
        if (wa_q.size() - wb == 10) begin
            for (int i = 0; i < 10; i++) begin
                check("wr_addr", wa_q[wb+i], ea[i]);
                check("wr_data", wd_q[wb+i], ed[i]);
                check("wr_cyc", wc_q[wb+i] - last_acc,
                      (i < 9) ? i + 1 : t_clr);
            end
        end
        @(negedge clk);
        check("done_pulse", done, 0);
        check("ready_back", bus.in_ready, 1);
        check("busy_idle", busy, 0);
        check("cycles_hold", cycles, (n == 0) ? 16 : n);
    endtask

    task automatic abort_job(input logic [31:0] w [4],
                             input int at);
        int g = 0;
        dev_n = 0;
        feed(w, 1'b0, 1'b0);
        while (cyc - last_acc < at && g < 100) begin
            @(posedge clk); #2;
            g++;
        end
        check("abort_bound", (g < 100), 1);
        check("pre_busy", busy, 1);
        check("pre_hwen", bus.hwen, (at <= 9));
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready", bus.in_ready, 1);
        check("rst_hwen", bus.hwen, 0);
        check("rst_hren", bus.hren, 0);
        check("rst_cycles", cycles, 0);
        @(posedge clk); #2;
        reset = 1'b1;
    endtask

    logic [31:0] wv [4];

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("r_ready", bus.in_ready, 1);
        check("r_busy", busy, 0);
        check("r_hwen", bus.hwen, 0);
        check("r_hren", bus.hren, 0);
        check("r_done", done, 0);
        check("r_matched", matched, 0);
        check("r_timeout", timeout, 0);
        check("r_addr", bus.addr, 0);
        check("r_wdata", bus.wdata, 0);
        check("r_cycles", cycles, 0);
        reset = 1'b1;

        wv = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_job(wv, 8'h5a, 3, 1'b1, 1'b0, 1'b1);

        wv = '{32'h1111_0001, 32'h2222_0002,
               32'h3333_0003, 32'h4444_0004};
        run_job(wv, 8'h01, 2, 1'b0, 1'b1, 1'b0);

        wv = '{32'hcafe_0000, 32'h0, 32'hffff_ffff, 32'h8000_0001};
        run_job(wv, 8'hc3, 0, 1'b1, 1'b0, 1'b0);

        wv = '{32'h0bad_f00d, 32'h1234_5678,
               32'h9abc_def0, 32'h5555_aaaa};
        run_job(wv, 8'h7e, 16, 1'b1, 1'b0, 1'b0);

        stale = 1'b1;
        wv = '{32'ha, 32'hb, 32'hc, 32'hd};
        run_job(wv, 8'h22, 5, 1'b0, 1'b0, 1'b0);
        stale = 1'b0;

        wv = '{32'h77, 32'h66, 32'h55, 32'h44};
        abort_job(wv, 3);
        abort_job(wv, 13);

        wv = '{32'h0101_0101, 32'h0202_0202,
               32'h0303_0303, 32'h0404_0404};
        run_job(wv, 8'h99, 4, 1'b1, 1'b0, 1'b0);

        check("strobes", bad_strb, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pd_driver.md
# pd_driver

Bus-master sequencer directly upstream of the codeword-matching peripheral device. It accepts `WRDS` 32-bit codewords over a valid/ready stream and drives the device's register port to run one job:
- load each codeword (PTR write, then DATA write);
- start the device with an interrupt-enabled CR write;
- wait for the interrupt, or time out;
- read ST, then clear CR.

It reports `matched` and the wait-cycle count to the upstream client.

## Interface
Parameters:
- `WRDS`, 4, number of codewords per job (device depth); pointer values 0..WRDS-1.
- `TIMEOUT`, 1024, maximum WAIT cycles before abort; must satisfy 1 ≤ TIMEOUT ≤ 65535.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  codeword available.
- `in_ready`  output  1  block accepts a codeword this cycle.
- `in_data`  input  32  codeword.
- `ctr_value`  input  8  device ctr field, sampled with the last codeword.
- `addr`  output  5  device register select (DATA=0, PTR=8, CR=16, ST=24).
- `hwen`  output  1  device write strobe.
- `hren`  output  1  device read strobe.
- `wdata`  output  32  device write data.
- `rdata`  input  32  device read data (combinational from `addr`).
- `interrupt`  input  1  device interrupt (int_enable && !running).
- `busy`  output  1  a job is in progress (not FILL).
- `done`  output  1  one-cycle pulse when the result is valid.
- `matched`  output  1  ST bit 10 from the last job; held until the next `done`.
- `timeout`  output  1  last job aborted by timeout; held until the next `done`.
- `cycles`  output  16  WAIT cycles of the last job; held until the next `done`.

## Operation
- All outputs are registered.
- Reset values: `in_ready`=1; `busy`, `hwen`, `hren`, `done`, `matched`, `timeout`=0; `addr`=0, `wdata`=0, `cycles`=0.
- FILL: `in_ready`=1.
  - Each `in_valid && in_ready` stores `in_data` at index k; k counts 0..WRDS-1.
  - On the WRDS-th accept, latch `ctr_value`, set `in_ready`=0 and `busy`=1, then go to LOAD.
- LOAD: for i = 0..WRDS-1, two write cycles per word:
  - PTR write: `addr`=8, `wdata`=i.
  - DATA write: `addr`=0, `wdata`=word[i].
- START: one write cycle, `addr`=16, `wdata`={22'b0, 1'b1 (int_enable), 1'b1 (running), ctr}.
- WAIT: `hwen`=`hren`=0.
  - Each cycle, increment the wait counter, saturating at TIMEOUT.
  - If `interrupt`=1, go to READ.
  - Else, if the counter has reached TIMEOUT, set the abort flag and go to CLEAR.
  - `interrupt` takes priority when both occur in the same cycle.
- READ: one cycle, `hren`=1, `addr`=24.
  - Capture `rdata[10]` into `matched` at the end of the cycle.
  - Then go to CLEAR.
- CLEAR: one write cycle, `addr`=16, `wdata`=0. This stops the device and drops `interrupt`.
- DONE:
  - Pulse `done` for one cycle.
  - Update outputs: `timeout`=abort flag; `matched`=0 if aborted; `cycles`=wait counter.
  - Return to FILL with k=0 and `in_ready`=1 in the cycle after the `done` pulse.
- `in_valid` while `in_ready`=0 is ignored; data is not consumed.
- Reset asserted mid-job: the block returns to FILL immediately, partial words are discarded, and bus strobes drop asynchronously.
  - The device is not cleared by this block.
  - A stale high `interrupt` is harmless: it is not sampled outside WAIT.

## Timing
- Let cycle 0 be the cycle of the last FILL accept.
- LOAD occupies cycles 1..2·WRDS; with WRDS=4 that is cycles 1..8.
- START write: cycle 2·WRDS+1.
- WAIT starts at cycle 2·WRDS+2.
  - The device's running flag is set at the START edge, so `interrupt` is already low here, even if it was high from a prior job.
- An interrupt first seen in WAIT cycle n (n=1 for the first WAIT cycle) gives:
  - READ at WAIT+n;
  - CLEAR at WAIT+n+1;
  - `done` at WAIT+n+2;
  - `cycles`=n.
- On timeout:
  - CLEAR occurs in the cycle after WAIT cycle TIMEOUT;
  - `done` follows one cycle later;
  - `cycles`=TIMEOUT.
- Exactly one strobe (`hwen` or `hren`) is high in each bus cycle; both are low in FILL, WAIT and DONE.

## Test plan
- Basic job, WRDS=4, words 1,2,3,4, ctr=0x5A, device model asserting `interrupt` in WAIT cycle 3 with ST bit 10=1 -> the bus write sequence PTR0, DATA1, PTR1, DATA2, PTR2, DATA3, PTR3, DATA4, then CR=0x35A; READ ST; CR=0; `done` with `matched`=1, `cycles`=3, `timeout`=0.
- Backpressure: `in_valid` toggled 1,0,1,0,... -> all 4 words are captured in order, and LOAD starts exactly one cycle after the 4th accept.
- Timeout with TIMEOUT=16 and `interrupt` held low -> no READ cycle; CR=0 written; `done` with `timeout`=1, `matched`=0, `cycles`=16.
- `interrupt` rises in WAIT cycle 16 with TIMEOUT=16 -> READ is taken and `timeout`=0.
- Back-to-back jobs: `interrupt` is high before the second START -> the second job's WAIT is not terminated early, and `cycles` reflects the second job only.
- Reset asserted during WAIT -> `busy`=0, `in_ready`=1 and strobes low immediately; the next 4 words run a full, correct job.
